// File: rtl/hsid_x_ctrl_reg_mc.sv
// rtl/hsid_x_ctrl_reg_mc.sv - multi-channel HSpecID-X control/status register block
// Optional per-channel busy-cycle counter (word 10) is built when HSID_X_CTRL_PERF_CNT_EN is defined.
module hsid_x_ctrl_reg_mc #(
  parameter int WORD_WIDTH = 32,
  parameter int HSI_BANDS = 128,
  parameter int HSI_LIBRARY_SIZE = 256,
  parameter int N_CHANNELS = 4,
  parameter int ADDR_WIDTH = 12,
  localparam int HSI_BANDS_ADDR = $clog2(HSI_BANDS),
  localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        reg_req,
  input  logic                                        reg_we,
  input  logic [ADDR_WIDTH-1:0]                       reg_addr,
  input  logic [WORD_WIDTH-1:0]                       reg_wdata,
  output logic [WORD_WIDTH-1:0]                       reg_rdata,
  output logic                                        reg_ack,
  output logic                                        reg_err,
  output logic [N_CHANNELS-1:0]                       start,
  output logic [N_CHANNELS-1:0]                       clear,
  input  logic [N_CHANNELS-1:0]                       idle,
  input  logic [N_CHANNELS-1:0]                       ready,
  input  logic [N_CHANNELS-1:0]                       done,
  input  logic [N_CHANNELS-1:0]                       error,
  output logic [N_CHANNELS*HSI_LIBRARY_SIZE_ADDR-1:0] library_size,
  output logic [N_CHANNELS*HSI_BANDS_ADDR-1:0]        pixel_bands,
  output logic [N_CHANNELS*WORD_WIDTH-1:0]            captured_pixel_addr,
  output logic [N_CHANNELS*WORD_WIDTH-1:0]            library_pixel_addr,
  input  logic [N_CHANNELS*HSI_LIBRARY_SIZE_ADDR-1:0] mse_min_ref,
  input  logic [N_CHANNELS*HSI_LIBRARY_SIZE_ADDR-1:0] mse_max_ref,
  input  logic [N_CHANNELS*WORD_WIDTH-1:0]            mse_min_value,
  input  logic [N_CHANNELS*WORD_WIDTH-1:0]            mse_max_value,
  output logic [N_CHANNELS-1:0]                       irq
);
  localparam int N  = N_CHANNELS;
  localparam int W  = WORD_WIDTH;
  localparam int LA = HSI_LIBRARY_SIZE_ADDR;
  localparam int BA = HSI_BANDS_ADDR;
  localparam int CW = ADDR_WIDTH - 6;
`ifdef HSID_X_CTRL_PERF_CNT_EN
  localparam logic [3:0] LAST_WORD = 4'd10;
`else
  localparam logic [3:0] LAST_WORD = 4'd9;
`endif

  logic [3:0]    word;
  logic [CW-1:0] ch_idx;
  logic          dec_err;
  logic          unused_addr_lsb;
  logic [N-1:0]  sel;

  logic          ack_q, ack_d, err_q, err_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic [N-1:0]  start_q, start_d, clear_q, clear_d, irq_en_q, irq_en_d;
  logic [N-1:0]  done_st_q, done_st_d, err_st_q, err_st_d, blk_q, blk_d;
  logic [N-1:0]  done_q, done_d, error_q, error_d, irq_q, irq_d;
  logic [N-1:0]  done_edge, err_edge, blk_set, clr_done, clr_err, clr_blk;
  logic [LA-1:0] lib_size_q [N], lib_size_d [N];
  logic [BA-1:0] bands_q [N], bands_d [N];
  logic [W-1:0]  cap_addr_q [N], cap_addr_d [N], lib_addr_q [N], lib_addr_d [N];
  logic [LA-1:0] min_ref_q [N], min_ref_d [N], max_ref_q [N], max_ref_d [N];
  logic [W-1:0]  min_val_q [N], min_val_d [N], max_val_q [N], max_val_d [N];

  assign word            = reg_addr[5:2];
  assign ch_idx          = reg_addr[ADDR_WIDTH-1:6];
  assign unused_addr_lsb = ^reg_addr[1:0];
  assign dec_err         = (ch_idx >= CW'(N)) || (word > LAST_WORD);
  assign done_edge       = done & ~done_q;
  assign err_edge        = error & ~error_q;

  for (genvar g = 0; g < N; g++) begin : g_ch
    assign sel[g]                         = reg_req && !dec_err && (ch_idx == CW'(g));
    assign library_size[g*LA +: LA]       = lib_size_q[g];
    assign pixel_bands[g*BA +: BA]        = bands_q[g];
    assign captured_pixel_addr[g*W +: W]  = cap_addr_q[g];
    assign library_pixel_addr[g*W +: W]   = lib_addr_q[g];
  end

  assign reg_ack   = ack_q;
  assign reg_err   = err_q;
  assign reg_rdata = rdata_q;
  assign start     = start_q;
  assign clear     = clear_q;
  assign irq       = irq_q;

  // Register writes, pulse generation, sticky status and result snapshots
  always_comb begin
    start_d = '0;
    clear_d = '0;
    blk_set = '0;
    clr_done = '0;
    clr_err = '0;
    clr_blk = '0;
    irq_en_d = irq_en_q;
    lib_size_d = lib_size_q;
    bands_d = bands_q;
    cap_addr_d = cap_addr_q;
    lib_addr_d = lib_addr_q;
    min_ref_d = min_ref_q;
    max_ref_d = max_ref_q;
    min_val_d = min_val_q;
    max_val_d = max_val_q;
    for (int c = 0; c < N; c++) begin
      if (sel[c] && reg_we) begin
        case (word)
          4'd0: begin
            irq_en_d[c] = reg_wdata[2];
            // CLEAR dominates START in the same write
            if (reg_wdata[1]) begin
              clear_d[c] = 1'b1;
              clr_done[c] = 1'b1;
              clr_err[c] = 1'b1;
              clr_blk[c] = 1'b1;
            end else if (reg_wdata[0]) begin
              if (idle[c]) start_d[c] = 1'b1;
              else blk_set[c] = 1'b1;
            end
          end
          4'd1: begin
            clr_done[c] = reg_wdata[2];
            clr_err[c] = reg_wdata[3];
            clr_blk[c] = reg_wdata[4];
          end
          4'd2: if (idle[c]) lib_size_d[c] = reg_wdata[LA-1:0]; else blk_set[c] = 1'b1;
          4'd3: if (idle[c]) bands_d[c] = reg_wdata[BA-1:0]; else blk_set[c] = 1'b1;
          4'd4: if (idle[c]) cap_addr_d[c] = reg_wdata; else blk_set[c] = 1'b1;
          4'd5: if (idle[c]) lib_addr_d[c] = reg_wdata; else blk_set[c] = 1'b1;
          default: ;
        endcase
      end
      if (done_edge[c]) begin
        min_ref_d[c] = mse_min_ref[c*LA +: LA];
        max_ref_d[c] = mse_max_ref[c*LA +: LA];
        min_val_d[c] = mse_min_value[c*W +: W];
        max_val_d[c] = mse_max_value[c*W +: W];
      end
    end
    // A set event in the same cycle as a clear keeps the bit set
    done_st_d = done_edge | (done_st_q & ~clr_done);
    err_st_d  = err_edge | (err_st_q & ~clr_err);
    blk_d     = blk_set | (blk_q & ~clr_blk);
    irq_d     = irq_en_q & (done_st_q | err_st_q);
    done_d    = done;
    error_d   = error;
  end

`ifdef HSID_X_CTRL_PERF_CNT_EN
  logic [W-1:0] cyc_q [N], cyc_d [N];

  // Busy-cycle counter: zeroed by start, saturating, frozen once DONE latches
  always_comb begin
    for (int c = 0; c < N; c++) begin
      cyc_d[c] = cyc_q[c];
      if (start_q[c]) cyc_d[c] = '0;
      else if (!idle[c] && !done_st_q[c] && (cyc_q[c] != '1)) cyc_d[c] = cyc_q[c] + W'(1);
    end
  end

  // Counter state
  always_ff @(posedge clk) begin
    for (int c = 0; c < N; c++) cyc_q[c] <= rst ? '0 : cyc_d[c];
  end
`endif

  // Read mux and bus response; errored or write accesses return zero data
  always_comb begin
    rdata_d = '0;
    ack_d = reg_req;
    err_d = reg_req && dec_err;
    for (int c = 0; c < N; c++) begin
      if (sel[c] && !reg_we) begin
        case (word)
          4'd0: rdata_d = W'({irq_en_q[c], 2'b00});
          4'd1: rdata_d = W'({blk_q[c], err_st_q[c], done_st_q[c], ready[c], idle[c]});
          4'd2: rdata_d = W'(lib_size_q[c]);
          4'd3: rdata_d = W'(bands_q[c]);
          4'd4: rdata_d = cap_addr_q[c];
          4'd5: rdata_d = lib_addr_q[c];
          4'd6: rdata_d = W'(min_ref_q[c]);
          4'd7: rdata_d = min_val_q[c];
          4'd8: rdata_d = W'(max_ref_q[c]);
          4'd9: rdata_d = max_val_q[c];
`ifdef HSID_X_CTRL_PERF_CNT_EN
          4'd10: rdata_d = cyc_q[c];
`endif
          default: rdata_d = '0;
        endcase
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      start_q <= '0;
      clear_q <= '0;
      irq_en_q <= '0;
      done_st_q <= '0;
      err_st_q <= '0;
      blk_q <= '0;
      done_q <= '0;
      error_q <= '0;
      irq_q <= '0;
      for (int c = 0; c < N; c++) begin
        lib_size_q[c] <= '0;
        bands_q[c] <= '0;
        cap_addr_q[c] <= '0;
        lib_addr_q[c] <= '0;
        min_ref_q[c] <= '0;
        max_ref_q[c] <= '0;
        min_val_q[c] <= '0;
        max_val_q[c] <= '0;
      end
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      clear_q <= clear_d;
      irq_en_q <= irq_en_d;
      done_st_q <= done_st_d;
      err_st_q <= err_st_d;
      blk_q <= blk_d;
      done_q <= done_d;
      error_q <= error_d;
      irq_q <= irq_d;
      lib_size_q <= lib_size_d;
      bands_q <= bands_d;
      cap_addr_q <= cap_addr_d;
      lib_addr_q <= lib_addr_d;
      min_ref_q <= min_ref_d;
      max_ref_q <= max_ref_d;
      min_val_q <= min_val_d;
      max_val_q <= max_val_d;
    end
  end

endmodule
